// File: rtl/wb_arbiter.sv
// Wishbone arbiter: controller 0 has fixed top priority, the others share the bus
// round-robin; grants open only in bus slots and a watchdog force-acks stuck transfers.
module wb_arbiter #(
    parameter int unsigned COUNT         = 3,
    parameter int unsigned WB_ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic                             wb_clock_i,
    input  logic                             wb_reset_ni,
    input  logic                             slot_valid_i,
    input  logic [COUNT-1:0]                 wbc_cycle_i,
    input  logic [COUNT-1:0]                 wbc_strobe_i,
    input  logic [COUNT-1:0]                 wbc_we_i,
    input  logic [COUNT*WB_ADDR_WIDTH-1:0]   wbc_addr_i,
    input  logic [COUNT*DATA_WIDTH-1:0]      wbc_dout_i,
    output logic [COUNT*DATA_WIDTH-1:0]      wbc_din_o,
    output logic [COUNT-1:0]                 wbc_stall_o,
    output logic [COUNT-1:0]                 wbc_ack_o,
    output logic [WB_ADDR_WIDTH-1:0]         wb_addr_o,
    output logic [DATA_WIDTH-1:0]            wb_dout_o,
    output logic                             wb_we_o,
    output logic                             wb_cycle_o,
    output logic                             wb_strobe_o,
    input  logic [DATA_WIDTH-1:0]            wb_din_i,
    input  logic                             wb_stall_i,
    input  logic                             wb_ack_i,
    output logic [$clog2(COUNT)-1:0]         grant_o,
    output logic                             grant_valid_o,
    output logic                             timeout_o
);

    localparam int unsigned IDX_W = $clog2(COUNT);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned OUT_W = 4;
    localparam logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(8'hFF);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_last_rr;
    logic               r_grant_valid;
    logic [OUT_W-1:0]   r_outstanding;
    logic [WD_W-1:0]    r_wdog;
    logic               r_timeout;

    logic [IDX_W-1:0]   w_winner;
    logic               w_rr_found;
    logic               w_any_req;
    logic               w_busy;
    logic               w_owner_cyc;
    logic               w_release;
    logic               w_accept;
    logic               w_real_ack;
    logic               w_ack_eff;
    logic               w_wd_run;

    assign w_any_req   = |wbc_cycle_i;
    assign w_busy      = (r_state == BUSY);
    assign w_owner_cyc = wbc_cycle_i[r_grant];
    assign w_release   = w_busy && !w_owner_cyc;
    assign w_accept    = w_busy && wb_strobe_o && !wb_stall_i;
    // An ack with nothing outstanding is spurious and is dropped
    assign w_real_ack  = w_busy && wb_ack_i && (r_outstanding != '0);
    assign w_ack_eff   = w_real_ack || r_timeout;
    assign w_wd_run    = w_busy && !w_release && (r_outstanding != '0) && !wb_ack_i && !r_timeout;

    assign grant_o       = r_grant;
    assign grant_valid_o = r_grant_valid;
    assign timeout_o     = r_timeout;

    // Winner selection: controller 0 first, then scan last_rr+1 .. COUNT-1, 1 .. last_rr
    always_comb begin : arbitrate
        int c;
        c          = 0;
        w_winner   = '0;
        w_rr_found = 1'b0;
        for (int k = 1; k < int'(COUNT); k++) begin
            c = int'(r_last_rr) + k;
            if (c >= int'(COUNT)) begin
                c = c - (int'(COUNT) - 1);
            end
            if (!w_rr_found && wbc_cycle_i[IDX_W'(c)]) begin
                w_rr_found = 1'b1;
                w_winner   = IDX_W'(c);
            end
        end
        if (wbc_cycle_i[0]) begin
            w_winner = '0;
        end
    end

    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin : state_reg
        if (!wb_reset_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : next_state
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (slot_valid_i && w_any_req) w_state_nxt = BUSY;
            BUSY:    if (!w_owner_cyc) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin : grant_reg
        if (!wb_reset_ni) begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_last_rr     <= IDX_W'(COUNT - 1);
        end else if (!w_busy && (w_state_nxt == BUSY)) begin
            r_grant       <= w_winner;
            r_grant_valid <= 1'b1;
            if (w_winner != '0) begin
                r_last_rr <= w_winner;
            end
        end else if (w_release) begin
            r_grant_valid <= 1'b0;
        end
    end

    // Outstanding transfers: +1 per accepted strobe, -1 per (real or forced) ack
    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin : outstanding_reg
        if (!wb_reset_ni) begin
            r_outstanding <= '0;
        end else if (w_release) begin
            r_outstanding <= '0;
        end else if (w_accept && !w_ack_eff) begin
            if (r_outstanding != '1) begin
                r_outstanding <= r_outstanding + OUT_W'(1);
            end
        end else if (!w_accept && w_ack_eff && (r_outstanding != '0)) begin
            r_outstanding <= r_outstanding - OUT_W'(1);
        end
    end

    // Watchdog: an ack arriving on the expiry edge resets the count, so the real ack wins
    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin : watchdog_reg
        if (!wb_reset_ni) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else if (!w_wd_run) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
            r_wdog    <= '0;
            r_timeout <= 1'b1;
        end else begin
            r_wdog    <= r_wdog + WD_W'(1);
            r_timeout <= 1'b0;
        end
    end

    always_comb begin : bus_mux
        wb_cycle_o  = w_busy;
        wb_strobe_o = 1'b0;
        wb_we_o     = 1'b0;
        wb_addr_o   = '0;
        wb_dout_o   = '0;
        if (w_busy) begin
            wb_strobe_o = wbc_strobe_i[r_grant];
            wb_we_o     = wbc_we_i[r_grant];
            wb_addr_o   = wbc_addr_i[int'(r_grant)*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
            wb_dout_o   = wbc_dout_i[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin : ctrl_mux
        for (int i = 0; i < int'(COUNT); i++) begin
            wbc_stall_o[i]                      = 1'b1;
            wbc_ack_o[i]                        = 1'b0;
            wbc_din_o[i*DATA_WIDTH +: DATA_WIDTH] = wb_din_i;
        end
        if (w_busy) begin
            wbc_stall_o[r_grant] = wb_stall_i;
            wbc_ack_o[r_grant]   = w_ack_eff;
            if (r_timeout && !w_real_ack) begin
                wbc_din_o[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH] = TIMEOUT_DATA;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// checked against a priority/round-robin reference model.
`timescale 1ns/1ps
module tb_wb_arbiter;

    localparam int COUNT = 3;
    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int TO    = 64;

    logic                  clk;
    logic                  rst_n;
    logic                  slot;
    logic [COUNT-1:0]      cyc, stb, we;
    logic [COUNT*AW-1:0]   addr;
    logic [COUNT*DW-1:0]   dout;
    logic [COUNT*DW-1:0]   din_o;
    logic [COUNT-1:0]      stall_o, ack_o;
    logic [AW-1:0]         bus_addr;
    logic [DW-1:0]         bus_dout, bus_din;
    logic                  bus_we, bus_cyc, bus_stb, bus_stall, bus_ack;
    logic [1:0]            grant;
    logic                  grant_valid, timeout;

    int n_checks;
    int n_errors;
    int m_last_rr;

    wb_arbiter #(
        .COUNT(COUNT), .WB_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .wb_clock_i(clk), .wb_reset_ni(rst_n), .slot_valid_i(slot),
        .wbc_cycle_i(cyc), .wbc_strobe_i(stb), .wbc_we_i(we),
        .wbc_addr_i(addr), .wbc_dout_i(dout), .wbc_din_o(din_o),
        .wbc_stall_o(stall_o), .wbc_ack_o(ack_o),
        .wb_addr_o(bus_addr), .wb_dout_o(bus_dout), .wb_we_o(bus_we),
        .wb_cycle_o(bus_cyc), .wb_strobe_o(bus_stb),
        .wb_din_i(bus_din), .wb_stall_i(bus_stall), .wb_ack_i(bus_ack),
        .grant_o(grant), .grant_valid_o(grant_valid), .timeout_o(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed priority for 0, then cyclic search over 1..COUNT-1 starting after last
    function automatic int model_winner(input logic [COUNT-1:0] req, input int last);
        int c;
        if (req[0]) return 0;
        for (int k = 1; k < COUNT; k++) begin
            c = ((last - 1 + k) % (COUNT - 1)) + 1;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [COUNT-1:0] onehot(input int g);
        logic [COUNT-1:0] v;
        v    = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; slot = 1'b0; cyc = '0; stb = '0; we = '0;
        addr = '0; dout = '0; bus_din = '0; bus_stall = 1'b0; bus_ack = 1'b0;
        repeat (2) step();
        n_checks++;
        if ({grant_valid, grant, timeout} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_grant: got %b exp 0000", {grant_valid, grant, timeout});
        end
        n_checks++;
        if ({bus_cyc, bus_stb, bus_we, bus_addr, bus_dout} !== '0) begin
            n_errors++; $display("FAIL reset_bus: got %h exp 0", {bus_cyc, bus_stb, bus_we, bus_addr, bus_dout});
        end
        n_checks++;
        if ({stall_o, ack_o} !== 6'b111_000) begin
            n_errors++; $display("FAIL reset_ctrl: got %b exp 111000", {stall_o, ack_o});
        end
        rst_n = 1'b1;
        m_last_rr = COUNT - 1;
        step();
    endtask

    task automatic test_priority();
        int exp;
        cyc = 3'b101; slot = 1'b1;
        exp = model_winner(cyc, m_last_rr);
        step();
        n_checks++;
        if ({grant_valid, bus_cyc, grant} !== {2'b11, 2'(exp)}) begin
            n_errors++; $display("FAIL prio_first: got %b exp %b", {grant_valid, bus_cyc, grant}, {2'b11, 2'(exp)});
        end
        if (exp != 0) m_last_rr = exp;
        cyc[0] = 1'b0;
        step();
        n_checks++;
        if ({grant_valid, bus_cyc, stall_o} !== 5'b00_111) begin
            n_errors++; $display("FAIL prio_dead_cycle: got %b exp 00111", {grant_valid, bus_cyc, stall_o});
        end
        exp = model_winner(cyc, m_last_rr);
        step();
        n_checks++;
        if ({grant_valid, grant} !== {1'b1, 2'(exp)}) begin
            n_errors++; $display("FAIL prio_second: got %b exp %b", {grant_valid, grant}, {1'b1, 2'(exp)});
        end
        if (exp != 0) m_last_rr = exp;
        cyc = '0;
        step();
    endtask

    task automatic test_round_robin();
        int exp;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        cyc = 3'b110; slot = 1'b1;
        for (int r = 0; r < 4; r++) begin
            exp = model_winner(cyc, m_last_rr);
            step();
            n_checks++;
            if ({grant_valid, grant} !== {1'b1, 2'(exp)}) begin
                n_errors++; $display("FAIL rr_grant[%0d]: got %b exp %b", r, {grant_valid, grant}, {1'b1, 2'(exp)});
            end
            if (exp != 0) m_last_rr = exp;
            a = AW'($urandom);
            stb[exp] = 1'b1; we[exp] = 1'b0; addr[exp*AW +: AW] = a; bus_stall = 1'b0;
            #1;
            n_checks++;
            if ({bus_stb, bus_addr, stall_o} !== {1'b1, a, ~onehot(exp)}) begin
                n_errors++; $display("FAIL rr_fwd[%0d]: got %h exp %h", r, {bus_stb, bus_addr, stall_o}, {1'b1, a, ~onehot(exp)});
            end
            step();
            stb[exp] = 1'b0; bus_ack = 1'b1; d = DW'($urandom); bus_din = d;
            #1;
            n_checks++;
            if ({ack_o, din_o} !== {onehot(exp), {COUNT{d}}}) begin
                n_errors++; $display("FAIL rr_ack[%0d]: got %h exp %h", r, {ack_o, din_o}, {onehot(exp), {COUNT{d}}});
            end
            step();
            bus_ack = 1'b0; cyc[exp] = 1'b0;
            step();
            n_checks++;
            if (grant_valid !== 1'b0) begin
                n_errors++; $display("FAIL rr_release[%0d]: got %b exp 0", r, grant_valid);
            end
            cyc[exp] = 1'b1;
        end
        cyc = '0;
        step();
    endtask

    task automatic test_slot_valid();
        int exp;
        cyc = 3'b010; slot = 1'b0;
        for (int h = 0; h < 5; h++) begin
            step();
            n_checks++;
            if ({bus_cyc, grant_valid} !== 2'b00) begin
                n_errors++; $display("FAIL slot_hold[%0d]: got %b exp 00", h, {bus_cyc, grant_valid});
            end
        end
        slot = 1'b1;
        exp = model_winner(cyc, m_last_rr);
        step();
        n_checks++;
        if ({bus_cyc, grant_valid, grant} !== {2'b11, 2'(exp)}) begin
            n_errors++; $display("FAIL slot_open: got %b exp %b", {bus_cyc, grant_valid, grant}, {2'b11, 2'(exp)});
        end
        if (exp != 0) m_last_rr = exp;
        slot = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({bus_cyc, grant_valid, grant} !== {2'b11, 2'(exp)}) begin
            n_errors++; $display("FAIL slot_no_preempt: got %b exp %b", {bus_cyc, grant_valid, grant}, {2'b11, 2'(exp)});
        end
        cyc = '0; slot = 1'b1;
        step();
        n_checks++;
        if (grant_valid !== 1'b0) begin
            n_errors++; $display("FAIL slot_release: got %b exp 0", grant_valid);
        end
    endtask

    task automatic test_timeout();
        int  exp;
        logic early;
        cyc = 3'b010; slot = 1'b1;
        exp = model_winner(cyc, m_last_rr);
        step();
        n_checks++;
        if ({grant_valid, grant} !== {1'b1, 2'(exp)}) begin
            n_errors++; $display("FAIL to_grant: got %b exp %b", {grant_valid, grant}, {1'b1, 2'(exp)});
        end
        if (exp != 0) m_last_rr = exp;
        stb[1] = 1'b1; we[1] = 1'b0; addr[AW +: AW] = 16'h8000; bus_stall = 1'b0; bus_din = '0;
        #1;
        n_checks++;
        if (bus_addr !== 16'h8000) begin
            n_errors++; $display("FAIL to_addr: got %h exp 8000", bus_addr);
        end
        step();
        stb[1] = 1'b0;
        early = 1'b0;
        for (int j = 1; j < TO; j++) begin
            step();
            if (timeout !== 1'b0 || ack_o !== '0) early = 1'b1;
        end
        step();
        n_checks++;
        if ({timeout, ack_o, din_o[DW +: DW]} !== {1'b1, 3'b010, 8'hFF}) begin
            n_errors++; $display("FAIL to_expiry: got %h exp %h", {timeout, ack_o, din_o[DW +: DW]}, {1'b1, 3'b010, 8'hFF});
        end
        step();
        n_checks++;
        if ({timeout, ack_o} !== 4'b0000) begin
            n_errors++; $display("FAIL to_one_cycle: got %b exp 0000", {timeout, ack_o});
        end
        n_checks++;
        if (early !== 1'b0) begin
            n_errors++; $display("FAIL to_early: got %b exp 0", early);
        end
        bus_ack = 1'b1;
        #1;
        n_checks++;
        if (ack_o !== 3'b000) begin
            n_errors++; $display("FAIL to_spurious: got %b exp 000", ack_o);
        end
        step();
        bus_ack = 1'b0;
        stb[1] = 1'b1;
        step();
        stb[1] = 1'b0;
        for (int j = 1; j < TO; j++) step();
        bus_ack = 1'b1; bus_din = 8'h5A;
        #1;
        n_checks++;
        if ({timeout, ack_o, din_o[DW +: DW]} !== {1'b0, 3'b010, 8'h5A}) begin
            n_errors++; $display("FAIL to_real_ack: got %h exp %h", {timeout, ack_o, din_o[DW +: DW]}, {1'b0, 3'b010, 8'h5A});
        end
        step();
        bus_ack = 1'b0;
        #1;
        n_checks++;
        if ({timeout, ack_o} !== 4'b0000) begin
            n_errors++; $display("FAIL to_real_wins: got %b exp 0000", {timeout, ack_o});
        end
        cyc = '0;
        step();
    endtask

    task automatic test_burst();
        int exp;
        logic [DW-1:0] d;
        cyc = 3'b100; slot = 1'b1;
        exp = model_winner(cyc, m_last_rr);
        step();
        n_checks++;
        if ({grant_valid, grant} !== {1'b1, 2'(exp)}) begin
            n_errors++; $display("FAIL burst_grant: got %b exp %b", {grant_valid, grant}, {1'b1, 2'(exp)});
        end
        if (exp != 0) m_last_rr = exp;
        stb[exp] = 1'b1; bus_stall = 1'b0;
        step();
        bus_stall = 1'b1;
        #1;
        n_checks++;
        if ({bus_stb, stall_o} !== 4'b1111) begin
            n_errors++; $display("FAIL burst_stall: got %b exp 1111", {bus_stb, stall_o});
        end
        step();
        bus_stall = 1'b0;
        step();
        step();
        stb[exp] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_ack = 1'b1; d = DW'($urandom); bus_din = d;
            #1;
            n_checks++;
            if ({ack_o, stall_o, din_o[exp*DW +: DW]} !== {onehot(exp), ~onehot(exp), d}) begin
                n_errors++; $display("FAIL burst_ack[%0d]: got %h exp %h", i, {ack_o, stall_o, din_o[exp*DW +: DW]}, {onehot(exp), ~onehot(exp), d});
            end
            step();
        end
        #1;
        n_checks++;
        if (ack_o !== 3'b000) begin
            n_errors++; $display("FAIL burst_extra_ack: got %b exp 000", ack_o);
        end
        step();
        bus_ack = 1'b0; cyc = '0;
        step();
    endtask

    task automatic test_reset_mid_busy();
        int exp;
        cyc = 3'b010; slot = 1'b1;
        exp = model_winner(cyc, m_last_rr);
        step();
        if (exp != 0) m_last_rr = exp;
        stb[1] = 1'b1; bus_stall = 1'b0;
        step();
        step();
        stb[1] = 1'b0; rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus_cyc, grant_valid, stall_o} !== 5'b00_111) begin
            n_errors++; $display("FAIL rst_busy: got %b exp 00111", {bus_cyc, grant_valid, stall_o});
        end
        step();
        rst_n = 1'b1;
        m_last_rr = COUNT - 1;
        exp = model_winner(cyc, m_last_rr);
        step();
        n_checks++;
        if ({grant_valid, grant} !== {1'b1, 2'(exp)}) begin
            n_errors++; $display("FAIL rst_regrant: got %b exp %b", {grant_valid, grant}, {1'b1, 2'(exp)});
        end
        if (exp != 0) m_last_rr = exp;
        bus_ack = 1'b1;
        #1;
        n_checks++;
        if (ack_o !== 3'b000) begin
            n_errors++; $display("FAIL rst_outstanding_cleared: got %b exp 000", ack_o);
        end
        step();
        bus_ack = 1'b0; cyc = '0;
        step();
    endtask

    task automatic test_random();
        int exp, hold, nx, ns;
        logic [COUNT-1:0] mask;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, d;
        logic w;
        for (int it = 0; it < 30; it++) begin
            mask = COUNT'($urandom_range(1, 7));
            cyc = mask; slot = 1'b0;
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                step();
                n_checks++;
                if ({grant_valid, bus_cyc} !== 2'b00) begin
                    n_errors++; $display("FAIL rnd_hold[%0d]: got %b exp 00", it, {grant_valid, bus_cyc});
                end
            end
            slot = 1'b1;
            exp = model_winner(cyc, m_last_rr);
            step();
            n_checks++;
            if ({grant_valid, grant} !== {1'b1, 2'(exp)}) begin
                n_errors++; $display("FAIL rnd_grant[%0d]: got %b exp %b", it, {grant_valid, grant}, {1'b1, 2'(exp)});
            end
            if (exp != 0) m_last_rr = exp;
            slot = 1'($urandom_range(0, 1));
            nx = $urandom_range(1, 3);
            for (int x = 0; x < nx; x++) begin
                a = AW'($urandom); wd = DW'($urandom); w = 1'($urandom_range(0, 1));
                stb[exp] = 1'b1; we[exp] = w; addr[exp*AW +: AW] = a; dout[exp*DW +: DW] = wd;
                ns = $urandom_range(0, 2);
                for (int s = 0; s <= ns; s++) begin
                    bus_stall = (s < ns);
                    #1;
                    n_checks++;
                    if ({bus_stb, bus_we, bus_addr, bus_dout, stall_o} !==
                        {1'b1, w, a, wd, (s < ns) ? {COUNT{1'b1}} : ~onehot(exp)}) begin
                        n_errors++; $display("FAIL rnd_fwd[%0d]: got %h exp %h", it, {bus_stb, bus_we, bus_addr, bus_dout, stall_o},
                                             {1'b1, w, a, wd, (s < ns) ? {COUNT{1'b1}} : ~onehot(exp)});
                    end
                    step();
                end
                stb[exp] = 1'b0; bus_stall = 1'b0; bus_ack = 1'b1; d = DW'($urandom); bus_din = d;
                #1;
                n_checks++;
                if ({grant, ack_o, din_o} !== {2'(exp), onehot(exp), {COUNT{d}}}) begin
                    n_errors++; $display("FAIL rnd_ack[%0d]: got %h exp %h", it, {grant, ack_o, din_o}, {2'(exp), onehot(exp), {COUNT{d}}});
                end
                step();
                bus_ack = 1'b0;
            end
            cyc[exp] = 1'b0;
            step();
            n_checks++;
            if (grant_valid !== 1'b0) begin
                n_errors++; $display("FAIL rnd_release[%0d]: got %b exp 0", it, grant_valid);
            end
        end
        cyc = '0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: bench did not complete");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_last_rr = COUNT - 1;
        test_reset();
        test_priority();
        test_round_robin();
        test_slot_valid();
        test_timeout();
        test_burst();
        test_reset_mid_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Shares the system Wishbone bus among several Wishbone controllers (video fetch, SPI bridge, future DMA) for access to the RAM bridge, register file and keyboard peripherals. Controller 0 (video, real-time) has fixed top priority; the rest are served round-robin. Grants begin only inside bus slots signalled by the timing block. A watchdog keeps a non-responding peripheral from hanging the bus.

## Interface

- COUNT, 3: number of controllers (2..8); index 0 = highest priority.
- WB_ADDR_WIDTH, common_pkg WB_ADDR_WIDTH: address width.
- DATA_WIDTH, common_pkg DATA_WIDTH: data width.
- TIMEOUT, 64: cycles an outstanding transfer may wait for ack before forced completion (≥2).

Ports:

- wb_clock_i  in  1  system clock (64 MHz).
- wb_reset_ni  in  1  asynchronous, active-low reset.
- slot_valid_i  in  1  bus slot open; new grants are issued only while 1.
- wbc_cycle_i  in  COUNT  per-controller CYC.
- wbc_strobe_i  in  COUNT  per-controller STB.
- wbc_we_i  in  COUNT  per-controller WE.
- wbc_addr_i  in  COUNT*WB_ADDR_WIDTH  address; slice i = controller i.
- wbc_dout_i  in  COUNT*DATA_WIDTH  write data, controller → bus.
- wbc_din_o  out  COUNT*DATA_WIDTH  read data, bus → controller.
- wbc_stall_o  out  COUNT  per-controller STALL.
- wbc_ack_o  out  COUNT  per-controller ACK.
- wb_addr_o, wb_dout_o, wb_we_o, wb_cycle_o, wb_strobe_o  out  per bus widths  shared bus outputs.
- wb_din_i, wb_stall_i, wb_ack_i  in  per bus widths  shared bus responses (already OR-combined).
- grant_o  out  $clog2(COUNT)  current owner index.
- grant_valid_o  out  1  grant_o is meaningful.
- timeout_o  out  1  one-cycle pulse on watchdog expiry.

## Operation

- States: IDLE, BUSY.
- IDLE, arbitration:
  - When slot_valid_i=1 and any wbc_cycle_i is set, select a winner.
  - Controller 0 wins if it requests.
  - Otherwise scan indices last_rr+1 … COUNT-1, 1 … last_rr and take the first requester.
  - Register grant_o, set grant_valid_o=1, go to BUSY.
  - last_rr updates only when a non-zero index is granted.
- BUSY, forwarding:
  - wb_cycle_o=1.
  - wb_strobe_o, wb_we_o, wb_addr_o and wb_dout_o are muxed combinationally from the granted slice.
  - wbc_stall_o[g]=wb_stall_i; all other stall bits are 1.
  - wbc_ack_o[g]=wb_ack_i; all other ack bits are 0.
  - wb_din_i is broadcast to every wbc_din_o slice. It is valid only with ack.
- Outstanding counter (4 bits):
  - +1 on accepted strobe (wb_strobe_o & !wb_stall_i).
  - -1 on ack.
  - Both in the same cycle: no change.
  - Saturates at 15 and never underflows. A spurious ack at 0 is ignored and not forwarded.
- Release:
  - When the granted controller drops its cycle, the next state is IDLE and grant_valid_o=0.
  - Leaving with outstanding≠0 clears the counter.
  - There is one dead cycle between grants; no back-to-back re-arbitration.
- slot_valid_i going 0 during BUSY does not preempt. The owner keeps the bus; the RAM bridge stalls itself.
- Watchdog:
  - Counts cycles in BUSY while outstanding≠0 and wb_ack_i=0. It resets on any ack or when outstanding=0.
  - On reaching TIMEOUT: pulse timeout_o, assert wbc_ack_o[g] for one cycle with wbc_din_o[g]=8'hFF, decrement outstanding, reset the counter.
- Idle outputs: wb_cycle_o=0, wb_strobe_o=0, wb_we_o=0, wb_addr_o=0, wb_dout_o=0, wbc_stall_o all 1, wbc_ack_o all 0.

## Timing

- Reset (async assert, synchronous release):
  - state=IDLE, grant_o=0, grant_valid_o=0, last_rr=COUNT-1, outstanding=0, watchdog=0, timeout_o=0.
  - Outputs take the idle values above.
- Arbitration latency: request sampled at edge N → bus cycle/strobe visible after edge N+1 (one cycle).
- Request with slot_valid_i=0: held off until the first edge where slot_valid_i=1.
- Bus outputs in BUSY are combinational from the controller inputs. There is no extra pipeline stage; stall/ack pass through in zero cycles.
- Release: cycle drop sampled at edge M → IDLE after M. Earliest new grant is visible after M+1.
- Watchdog: strobe accepted at edge S with no ack → forced ack during the cycle following edge S+TIMEOUT.
- Simultaneous real ack and expiry: the real ack wins and no timeout_o.
- Request from controller 0 during another grant: waits for release; no preemption.

## Test plan

- Reset mid-BUSY (wb_reset_ni low while controller 1 owns with outstanding=2) → next cycle wb_cycle_o=0, grant_valid_o=0, all stalls 1. After release, controller 1 re-arbitrates normally.
- Controller 0 and 2 request together in IDLE with slot_valid_i=1 → grant_o=0 one cycle later. Controller 2 is granted after controller 0 drops its cycle plus one idle cycle.
- COUNT=3, controllers 1 and 2 hold requests continuously, each releasing after one read → grant sequence 1,2,1,2, with an idle cycle between each.
- slot_valid_i=0 for 5 cycles with a pending request → no wb_cycle_o until slot_valid_i=1, then grant. Dropping slot_valid_i mid-BUSY does not release.
- Controller 1 reads 0x8000 with wb_ack_i withheld, TIMEOUT=64 → exactly 64 cycles after acceptance: timeout_o=1 for one cycle, wbc_ack_o[1]=1, wbc_din_o slice 1=8'hFF.
- Pipelined burst of 3 strobes with wb_stall_i asserted on the 2nd → outstanding increments only on unstalled strobes. Three acks return to the owner only; non-owners see stall=1 and ack=0 throughout.
